bits_to_chars_deser: RTL and testbench

- Synthesizable receive-side counterpart of the testbench string-to-bipolar encoding.
- Accepts a serial stream of signed fixed-point soft samples (positive = logic 1, negative = logic 0), slices each sample to a hard bit, and packs the bits MSB-first into 8-bit characters.
- Completed characters are buffered in a small FIFO and presented on a valid/ready output with per-message framing.
- Sits after the demodulator/soft-bit source and feeds the character sink or scoreboard.

---
 rtl/deser_pkg.sv | 11 +
 rtl/sync_fifo.sv | 51 +++++
 rtl/bits_to_chars_deser.sv | 115 +++++++++++
 tb/tb_bits_to_chars_deser.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
// Shared types for the soft-bit to character deserializer.
package deser_pkg;
    localparam int unsigned CHAR_W = 8;

    typedef enum logic {IDLE, SHIFT} deser_state_t;

    typedef struct packed {
        logic              last;
        logic [CHAR_W-1:0] ch;
    } char_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Registered first-word-fall-through FIFO; pop_data reads zero while empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/bits_to_chars_deser.sv
// Slices signed soft samples to hard bits, packs them MSB-first into
// characters and buffers completed characters with message framing.
module bits_to_chars_deser
    import deser_pkg::*;
#(
    parameter int unsigned SAMPLE_W   = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned MAX_CHARS  = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [SAMPLE_W-1:0]            in_sample,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [7:0]                     out_char,
    output logic                           out_last,
    output logic [$clog2(MAX_CHARS+1)-1:0] char_count,
    output logic                           frame_err,
    output logic                           busy
);
    localparam int unsigned CNT_W = $clog2(MAX_CHARS+1);

    deser_state_t              state;
    deser_state_t              state_next;
    logic [2:0]                bit_cnt;
    logic [CHAR_W-2:0]         shreg;
    logic                      accept;
    logic                      hard_bit;
    logic                      push;
    logic                      frame_hit;
    logic                      clear_pend;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    char_entry_t               push_entry;
    char_entry_t               pop_entry;
    logic                      unused_sample_bits;

    assign accept   = in_valid && in_ready;
    assign hard_bit = ~in_sample[SAMPLE_W-1];
    assign unused_sample_bits = ^in_sample[SAMPLE_W-2:0];
    assign in_ready = !fifo_full;

    // Only the 7 earlier bits are stored; the 8th joins them on the push.
    assign push_entry = '{last: in_last, ch: {shreg, hard_bit}};

    always_comb begin
        state_next = state;
        push       = 1'b0;
        frame_hit  = 1'b0;
        if (accept) begin
            if (in_last) begin
                state_next = IDLE;
                if (bit_cnt == 3'd7) push = 1'b1;
                else                 frame_hit = 1'b1;
            end else begin
                state_next = SHIFT;
                if (bit_cnt == 3'd7) push = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            frame_err  <= 1'b0;
            clear_pend <= 1'b0;
            char_count <= '0;
        end else begin
            if (frame_hit) begin
                bit_cnt <= '0;
                shreg   <= '0;
            end else if (accept) begin
                bit_cnt <= bit_cnt + 3'd1;
                shreg   <= {shreg[CHAR_W-3:0], hard_bit};
            end
            frame_err  <= frame_hit;
            clear_pend <= push && in_last;
            // The count stays visible for one cycle after the closing push.
            if (clear_pend || frame_err)
                char_count <= '0;
            else if (push && char_count != CNT_W'(MAX_CHARS))
                char_count <= char_count + 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(char_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (out_ready),
        .pop_data  (pop_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign out_char  = pop_entry.ch;
    assign out_last  = pop_entry.last;
    assign busy      = (state == SHIFT) || (fifo_count != '0);
endmodule

// File: tb/tb_bits_to_chars_deser.sv
// Scoreboard bench: stimulus pushes expected characters, a negedge monitor pops and compares.
module tb_bits_to_chars_deser;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] in_sample = '0;
    logic               in_last = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [7:0]         out_char;
    logic               out_last;
    logic [6:0]         char_count;
    logic               frame_err;
    logic               busy;

    typedef struct packed {
        logic       last;
        logic [7:0] ch;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   pops = 0;
    int   fe_cycles = 0;
    logic held = 1'b0;
    logic [7:0] held_ch = '0;
    logic held_last = 1'b0;
    logic rand_ready = 1'b0;

    bits_to_chars_deser #(
        .SAMPLE_W   (16),
        .FIFO_DEPTH (8),
        .MAX_CHARS  (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sample  (in_sample),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_char   (out_char),
        .out_last   (out_last),
        .char_count (char_count),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (frame_err === 1'b1) fe_cycles++;
            if (rst) begin
                held = 1'b0;
            end else begin
                if (held && out_valid) begin
                    check("hold_char", out_char, held_ch);
                    check("hold_last", out_last, held_last);
                end
                if (out_valid && out_ready) begin
                    pops++;
                    if (q.size() == 0) begin
                        check("unexpected_char", out_char, -1);
                    end else begin
                        e = q.pop_front();
                        check("out_char", out_char, e.ch);
                        check("out_last", out_last, e.last);
                    end
                end
                held      = out_valid && !out_ready;
                held_ch   = out_char;
                held_last = out_last;
            end
        end
    end

    initial begin : ready_toggler
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send_bit(input logic b, input logic last, input logic zero_mode);
        logic ok;
        int   n;
        if (zero_mode) in_sample = b ? 16'sd0 : -16'sd1;
        else           in_sample = b ? 16'sd16384 : -16'sd16384;
        in_valid = 1'b1;
        in_last  = last;
        n = 0;
        forever begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            if (ok) break;
            n++;
            if (n > 3000) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_char(input logic [7:0] ch, input logic last, input logic zero_mode, input int max_gap);
        for (int i = 7; i >= 0; i--) begin
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) begin
                @(posedge clk);
                #1;
            end
            send_bit(ch[i], last && (i == 0), zero_mode);
        end
        q.push_back('{last: last, ch: ch});
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(name, q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        int p0;
        int fe0;
        logic [7:0] rc;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_char", out_char, 0);
        check("rst_out_last", out_last, 0);
        check("rst_char_count", char_count, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // "Hi"
        out_ready = 1'b1;
        send_char(8'h48, 1'b0, 1'b0, 0);
        check("hi_count1", char_count, 1);
        send_char(8'h69, 1'b1, 1'b0, 0);
        check("hi_count2", char_count, 2);
        @(posedge clk);
        #1;
        check("hi_count_clear", char_count, 0);
        drain("hi_drain");
        check("hi_no_frame_err", fe_cycles, 0);

        // zero decodes to one
        send_char(8'hA5, 1'b1, 1'b1, 0);
        drain("a5_drain");

        // back-pressure: nine chars with sink stalled
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_char(8'(8'h41 + i), 1'b0, 1'b0, 0);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_busy", busy, 1);
        fork
            send_char(8'h49, 1'b1, 1'b0, 0);
            begin
                repeat (4) @(posedge clk);
                #1;
                check("bp_in_ready_still_low", in_ready, 0);
                out_ready = 1'b1;
                @(posedge clk);
                #1;
                check("bp_in_ready_back", in_ready, 1);
            end
        join
        drain("bp_drain");

        // framing error on the 5th bit of the second byte
        fe0 = fe_cycles;
        send_char(8'h41, 1'b0, 1'b0, 0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, i == 4, 1'b0);
        check("fe_pulse_now", frame_err, 1);
        repeat (3) @(posedge clk);
        #1;
        check("fe_pulse_width", fe_cycles - fe0, 1);
        check("fe_count_clear", char_count, 0);
        check("fe_not_busy", busy, 0);
        drain("fe_drain");
        send_char(8'h5A, 1'b1, 1'b0, 0);
        drain("fe_recover_drain");

        // reset mid-message
        out_ready = 1'b0;
        send_char(8'h31, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_count", char_count, 0);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        p0 = pops;
        send_char(8'h7E, 1'b1, 1'b0, 0);
        drain("rst_recover_drain");
        check("rst_single_output", pops - p0, 1);

        // random traffic
        rand_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            rc = 8'($urandom_range(0, 255));
            send_char(rc, (i % 13 == 12) || (i == 199), 1'b0, 2);
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain("rand_drain");
        check("total_frame_err_cycles", fe_cycles, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
